// File: rtl/alu_seq_exec.sv
// Execution-stage ALU with a registered result and zero flag.
// Single-cycle ops (AND/OR/ADD/SUB/SLL/SRL/SLT) complete one cycle after they
// are accepted; MUL runs a fixed-latency iterative shift-add engine and holds
// busy high while it iterates.
module alu_seq_exec #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_next;

    // Single-cycle operations; MUL is never routed through here.
    function automatic logic [WIDTH-1:0] alu_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic [WIDTH-1:0]        r;
        xs = $signed(x);
        ys = $signed(y);
        r  = '0;
        case (op)
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_ADD: r = x + y;
            OP_SUB: r = x - y;
            OP_SLL: r = x << y[SHW-1:0];
            OP_SRL: r = x >> y[SHW-1:0];
            OP_SLT: r = {{(WIDTH-1){1'b0}}, (xs < ys)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Combinational result of the single-cycle ops and the next partial product.
    always_comb begin
        alu_res  = alu_op(alu_control, a, b);
        acc_next = mplier[0] ? (acc + mcand) : acc;
    end

    // Control FSM, multiply engine and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            zero   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (alu_control == OP_MUL) begin
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            count  <= CNT_W'(WIDTH);
                            busy   <= 1'b1;
                            state  <= MUL;
                        end else begin
                            result <= alu_res;
                            zero   <= (alu_res == '0);
                            done   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    // Fixed WIDTH iterations; no early exit when mplier empties.
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        result <= acc_next;
                        zero   <= (acc_next == '0);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
